// File: rtl/tia_capture_pkg.sv
// tia_capture_pkg: shared FSM states, TIA line timing constants and the pixel record layout
package tia_capture_pkg;
  typedef enum logic [1:0] {SEEK_VSYNC, IN_VSYNC, ACTIVE} state_e;
  localparam int TIA_LINE_CLOCKS = 228;
  localparam int TIA_HBLANK_CLOCKS = 68;
  typedef struct packed {
    logic       sof;
    logic [8:0] y;
    logic [7:0] x;
    logic [7:0] color;
  } pix_t;
endpackage

// File: rtl/tia_frame_capture_if.sv
// tia_frame_capture_if: valid/ready pixel stream {color,x,y,sof}; master drives pixels, slave drives ready
interface tia_frame_capture_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_color;
  logic [7:0] pix_x;
  logic [8:0] pix_y;
  logic       pix_sof;
  modport master(output pix_valid, pix_color, pix_x, pix_y, pix_sof, input pix_ready);
  modport slave(input pix_valid, pix_color, pix_x, pix_y, pix_sof, output pix_ready);
endinterface

// File: rtl/tia_frame_capture_fifo.sv
// capture_fifo: first-word fall-through pixel FIFO (push_i/din_i in, pop_i/dout_o/valid_o out, full_o); a push while full is dropped
module capture_fifo
  import tia_capture_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic push_i,
  input  pix_t din_i,
  input  logic pop_i,
  output pix_t dout_o,
  output logic valid_o,
  output logic full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  pix_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic wr, rd;
  // full is judged on the occupancy at the start of the cycle, so a same-cycle pop cannot rescue a push
  assign full_o  = cnt_q == CW'(DEPTH);
  assign valid_o = cnt_q != '0;
  assign wr      = push_i && !full_o;
  assign rd      = pop_i && valid_o;
  assign dout_o  = valid_o ? mem_q[rd_q] : '0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wr_q <= wr_q + 1'b1;
      if (rd) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clock) begin
    if (wr) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/tia_frame_capture.sv
// tia_frame_capture: recovers frame/line timing from TIA composite sync and streams coordinate-tagged visible pixels
//   clock/reset          : oscillator clock, async active-high reset
//   l_i/c_i/syn_i/blk_bar_i : TIA luma, chroma, composite sync, blank (low = blanked)
//   pix                  : valid/ready pixel stream {color={c,l,0}, x, y, sof}
//   frame_done_o/frame_count_o : vsync-while-active pulse and completed frame count
//   locked_o/overflow_o  : timing lock, sticky dropped-pixel flag
module tia_frame_capture
  import tia_capture_pkg::*;
#(
  parameter int VSYNC_MIN  = 64,
  parameter int MAX_WIDTH  = 160,
  parameter int MAX_LINES  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0]                 l_i,
  input  logic [3:0]                 c_i,
  input  logic                       syn_i,
  input  logic                       blk_bar_i,
  tia_frame_capture_if.master        pix,
  output logic                       frame_done_o,
  output logic [15:0]                frame_count_o,
  output logic                       locked_o,
  output logic                       overflow_o
);
  state_e      state_q;
  logic [2:0]  l_q;
  logic [3:0]  c_q;
  logic        syn_q, syn_p_q, blk_q;
  logic [7:0]  len_q, len_d;
  logic [7:0]  x_q;
  logic [8:0]  y_q;
  logic        sof_q, lhp_q, frame_done_q, overflow_q;
  logic [15:0] frame_count_q;
  logic        rise, fall, vs, vis, hs_end, in_range, push, full;
  pix_t        dout;
  assign rise     = syn_q && !syn_p_q;
  assign fall     = !syn_q && syn_p_q;
  assign len_d    = rise ? 8'd1 : (syn_q && len_q != 8'hFF) ? len_q + 8'd1 : len_q;
  // fires only on the cycle the run length steps onto VSYNC_MIN, hence once per syn-high run
  assign vs       = syn_q && len_d == 8'(VSYNC_MIN) && len_d != len_q;
  assign vis      = blk_q && !syn_q;
  assign hs_end   = fall && len_q < 8'(VSYNC_MIN);
  assign in_range = x_q < 8'(MAX_WIDTH) && y_q < 9'(MAX_LINES);
  assign push     = state_q == ACTIVE && !vs && !hs_end && vis && in_range;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= SEEK_VSYNC;
      {l_q, c_q, syn_q, syn_p_q, blk_q} <= '0;
      len_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      sof_q         <= 1'b0;
      lhp_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      {l_q, c_q, syn_q, blk_q, syn_p_q} <= {l_i, c_i, syn_i, blk_bar_i, syn_q};
      len_q        <= len_d;
      frame_done_q <= 1'b0;
      if (push && full) overflow_q <= 1'b1;
      case (state_q)
        SEEK_VSYNC: if (vs) state_q <= IN_VSYNC;
        IN_VSYNC: if (fall) begin
          state_q <= ACTIVE;
          x_q     <= '0;
          y_q     <= '0;
          sof_q   <= 1'b1;
          lhp_q   <= 1'b0;
        end
        ACTIVE: if (vs) begin
          frame_done_q  <= 1'b1;
          frame_count_q <= frame_count_q + 16'd1;
          state_q       <= IN_VSYNC;
        end else if (hs_end) begin
          x_q <= '0;
          if (lhp_q) begin
            y_q   <= y_q < 9'(MAX_LINES) ? y_q + 9'd1 : y_q;
            lhp_q <= 1'b0;
          end
        end else if (vis) begin
          lhp_q <= 1'b1;
          if (in_range) begin
            x_q   <= x_q + 8'd1;
            sof_q <= 1'b0;
          end
        end
        default: state_q <= SEEK_VSYNC;
      endcase
    end
  end
  capture_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (push),
    .din_i  (pix_t'({sof_q, y_q, x_q, c_q, l_q, 1'b0})),
    .pop_i  (pix.pix_ready),
    .dout_o (dout),
    .valid_o(pix.pix_valid),
    .full_o (full)
  );
  assign pix.pix_color  = dout.color;
  assign pix.pix_x      = dout.x;
  assign pix.pix_y      = dout.y;
  assign pix.pix_sof    = dout.sof;
  assign frame_done_o   = frame_done_q;
  assign frame_count_o  = frame_count_q;
  assign locked_o       = state_q != SEEK_VSYNC;
  assign overflow_o     = overflow_q;
endmodule

// File: tb/tb_tia_frame_capture.sv
// tb_tia_frame_capture: randomized line/frame stimulus with a line-level reference model and a scoreboard monitor
module tb_tia_frame_capture;
  import tia_capture_pkg::*;
  localparam int HS  = 16;
  localparam int HB  = TIA_HBLANK_CLOCKS - HS;
  localparam int VIS = TIA_LINE_CLOCKS - TIA_HBLANK_CLOCKS;
  logic clk = 0, rst = 1, syn = 0, blk = 0, ready = 1;
  logic [2:0] l = 0;
  logic [3:0] c = 0;
  logic frame_done, locked, overflow;
  logic [15:0] frame_count;
  logic [25:0] exp_q[$];
  int n_chk = 0, n_pass = 0, cyc = 0, fd_n = 0, lat_cyc = 0;
  int m_x = 0, m_y = 0, m_sof = 0, m_lp = 0, m_act = 0;
  bit lat_arm = 0;
  tia_frame_capture_if pif();
  assign pif.pix_ready = ready;
  tia_frame_capture dut (
    .clock(clk), .reset(rst), .l_i(l), .c_i(c), .syn_i(syn), .blk_bar_i(blk), .pix(pif),
    .frame_done_o(frame_done), .frame_count_o(frame_count), .locked_o(locked), .overflow_o(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (pif.pix_valid && exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pixel got=%0h exp=none", {pif.pix_sof, pif.pix_y, pif.pix_x, pif.pix_color});
      end else if (pif.pix_valid && ready) begin
        chk("pixel", {6'd0, pif.pix_sof, pif.pix_y, pif.pix_x, pif.pix_color}, {6'd0, exp_q.pop_front()});
        if (lat_arm) begin
          lat_arm = 0;
          chk("latency", cyc - lat_cyc, 2);
        end
      end else if (pif.pix_valid) chk("hold_x", pif.pix_x, exp_q[0][15:8]);
      if (frame_done) fd_n++;
    end
  end
  task automatic drv(input logic s, input logic b, input logic [2:0] ll, input logic [3:0] cc);
    syn = s; blk = b; l = ll; c = cc;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1;
    exp_q.delete();
    {m_x, m_y, m_sof, m_lp, m_act} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    fd_n = 0;
  endtask
  task automatic vsync(input int n);
    repeat (n) drv(1, 0, 0, 0);
    m_x = 0; m_y = 0; m_sof = 1; m_lp = 0; m_act = 1;
  endtask
  task automatic hsync(input int n);
    repeat (n) drv(1, 0, 0, 0);
    m_x = 0;
    if (m_lp) begin
      if (m_y < 256) m_y++;
      m_lp = 0;
    end
  endtask
  task automatic blank(input int n);
    repeat (n) drv(0, 0, 0, 0);
  endtask
  task automatic pixels(input int n, input int cap, input bit rnd, input logic [2:0] fl, input logic [3:0] fc);
    int kept = 0;
    logic [2:0] ll;
    logic [3:0] cc;
    for (int i = 0; i < n; i++) begin
      ll = rnd ? 3'($urandom) : fl;
      cc = rnd ? 4'($urandom) : fc;
      if (m_act && m_x < 160 && m_y < 256) begin
        if (kept < cap) begin
          exp_q.push_back({m_sof[0], 9'(m_y), 8'(m_x), cc, ll, 1'b0});
          kept++;
        end
        m_x++;
        m_sof = 0;
      end
      m_lp = 1;
      drv(0, 1, ll, cc);
    end
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(posedge clk);
    #1 chk(name, exp_q.size(), 0);
  endtask
  task automatic frame(input logic [2:0] fl, input logic [3:0] fc);
    for (int i = 0; i < 262; i++) begin
      if (i > 0) hsync(HS);
      blank(4);
      pixels($urandom_range(1, 12), 999, 0, fl, fc);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int bad = 0;
    logic [2:0] fl;
    logic [3:0] fc;
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_valid", pif.pix_valid, 0);
    chk("rst_color", pif.pix_color, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_done", frame_done, 0);
    for (int i = 0; i < 1000; i++) begin
      drv(0, 0, 0, 0);
      if (locked || pif.pix_valid) bad++;
    end
    chk("idle_quiet", bad, 0);
    do_reset();
    vsync(684 + HS);
    blank(HB);
    lat_cyc = cyc;
    lat_arm = 1;
    pixels(VIS, 999, 1, 0, 0);
    for (int ln = 1; ln < 3; ln++) begin
      hsync(HS);
      blank(HB);
      pixels(VIS, 999, 1, 0, 0);
    end
    blank(10);
    drain("t2_drain");
    chk("t2_no_frame_done", fd_n, 0);
    chk("t2_latency_seen", lat_arm, 0);
    chk("t2_overflow", overflow, 0);
    chk("t2_locked", locked, 1);
    do_reset();
    fl = 3'($urandom);
    fc = 4'($urandom);
    vsync(80);
    chk("t3_no_pulse_first", fd_n, 0);
    blank(4);
    frame(fl, fc);
    vsync(80);
    chk("t3_count1", frame_count, 1);
    chk("t3_pulses1", fd_n, 1);
    blank(4);
    frame(fl, fc);
    vsync(80);
    chk("t3_count2", frame_count, 2);
    chk("t3_pulses2", fd_n, 2);
    blank(10);
    drain("t3_drain");
    do_reset();
    vsync(80);
    blank(4);
    ready = 0;
    pixels(VIS, 16, 1, 0, 0);
    blank(4);
    chk("t4_overflow", overflow, 1);
    chk("t4_valid", pif.pix_valid, 1);
    chk("t4_x", pif.pix_x, 0);
    ready = 1;
    drain("t4_drain");
    do_reset();
    vsync(80);
    blank(4);
    pixels(200, 999, 1, 0, 0);
    hsync(HS);
    blank(4);
    pixels(10, 999, 1, 0, 0);
    blank(10);
    drain("t5_drain");
    do_reset();
    vsync(80);
    blank(4);
    ready = 0;
    pixels(8, 8, 1, 0, 0);
    blank(2);
    chk("t6_valid_before", pif.pix_valid, 1);
    rst = 1;
    exp_q.delete();
    {m_x, m_y, m_sof, m_lp, m_act} = '0;
    #1;
    chk("t6_valid_async", pif.pix_valid, 0);
    chk("t6_locked_async", locked, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    ready = 1;
    hsync(HS);
    blank(4);
    pixels(30, 999, 1, 0, 0);
    blank(4);
    chk("t6_no_output", pif.pix_valid, 0);
    chk("t6_unlocked", locked, 0);
    vsync(80);
    blank(4);
    pixels(20, 999, 1, 0, 0);
    blank(5);
    drain("t6_drain");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
